// File: rtl/shift_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide by zero completes in one cycle with all-ones quotient and the dividend as remainder.
module shift_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StZero} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] divd;
  logic [WIDTH-1:0] divs;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  // The partial remainder stays below the divisor, so trial < 2*divisor and the borrow
  // bit of the WIDTH+1 bit subtraction is exactly the "trial < divisor" flag.
  always_comb begin
    trial    = {part_rem, shreg[WIDTH-1]};
    diff     = trial - {1'b0, divs};
    q_next   = {shreg[WIDTH-2:0], 1'b0};
    rem_next = trial[WIDTH-1:0];
    if (!diff[WIDTH]) begin
      rem_next  = diff[WIDTH-1:0];
      q_next[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      part_rem    <= '0;
      shreg       <= '0;
      divd        <= '0;
      divs        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            divd     <= dividend;
            divs     <= divisor;
            busy     <= 1'b1;
            cnt      <= '0;
            part_rem <= '0;
            shreg    <= dividend;
            state    <= (divisor == '0) ? StZero : StRun;
          end
        end
        StRun: begin
          part_rem <= rem_next;
          shreg    <= q_next;
          cnt      <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            quotient    <= q_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= StIdle;
          end
        end
        StZero: begin
          quotient    <= '1;
          remainder   <= divd;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_divider.sv
// Scoreboard bench for shift_divider: driver pushes expected results, negedge monitor checks.
module tb_shift_divider;
  localparam int W = 8;

  logic         clk, rst, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, busy_run = 0, n_acc = 0, n_done = 0;

  shift_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        n_done++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dz);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_run, e.lat);
          if (e.b != 0) begin
            chk("identity", quotient * e.b + remainder, e.a);
            chk("rem_lt_div", remainder < e.b, 1);
          end
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      chk("issue_timeout", 1, 0);
      return;
    end
    e.a   = a;
    e.b   = b;
    e.dz  = (b == 0);
    e.q   = (b == 0) ? {W{1'b1}} : W'(a / b);
    e.r   = (b == 0) ? a : W'(a % b);
    e.lat = (b == 0) ? 1 : W;
    e.cyc = cyc + 1 + e.lat;
    sbq.push_back(e);
    n_acc++;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #22;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    issue(100, 7);
    issue(200, 8);
    issue(255, 1);
    issue(3, 200);
    issue(255, 255);
    issue(5, 0);
    issue(9, 3);
    drain();

    // Start while busy must be ignored; the follow-up lands on the done cycle.
    issue(100, 7);
    repeat (3) @(negedge clk);
    dividend = 50;
    divisor  = 5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    issue(50, 5);
    drain();

    // Asynchronous reset mid-operation: no clock edge needed, no done afterwards.
    @(negedge clk);
    dividend = 77;
    divisor  = 6;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dz", div_by_zero, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(77, 6);
    drain();

    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    chk("done_count", n_done, n_acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
